pri_queue_param: RTL and testbench
==================================

// Module: pri_queue_param
// PURPOSE
//   Parametrised sorted priority queue: next generation of the fixed 6-deep, max-first queue.
//   Adds configurable depth, min/max ordering, per-entry valid bits and ready/valid handshakes.
//   Supports full/empty/count reporting and a same-cycle insert+remove.
//   Sits between a producer of keyed requests and a consumer that always takes the best key.
// PARAMETERS
//   W          8   key width in bits
//   DEPTH      6   number of entries (>=2)
//   MAX_FIRST  1   1: largest key at top; 0: smallest key at top
//   CW         $clog2(DEPTH+1)   count width (derived, not overridden)
// PORTS
//   ck         in   1      clock, all state updates on posedge
//   r          in   1      reset, asynchronous, active-high
//   clear      in   1      synchronous flush, highest priority after reset
//   in_valid   in   1      producer offers in_data this cycle
//   in_ready   out  1      queue accepts in_data this cycle
//   in_data    in   W      key to insert
//   out_valid  out  1      top holds a valid key (== ~empty)
//   out_ready  in   1      consumer removes top this cycle
//   top        out  W      best key; 0 when empty
//   count      out  CW     number of valid entries
//   full       out  1      count == DEPTH
//   empty      out  1      count == 0
// BEHAVIOUR
//   - State: e[0..DEPTH-1] (W bits) and v[0..DEPTH-1], kept contiguous (v[i+1] implies v[i]).
//     e[0] is top. Invalid entries hold 0.
//   - Reset (r=1, async): all e=0, v=0. Outputs: count=0, empty=1, full=0, out_valid=0, top=0,
//     in_ready=1. Reset asserted mid-operation discards all contents immediately.
//   - Ordering "better(a,b)": a>b if MAX_FIRST, else a<b; unsigned compare.
//     Equal keys keep arrival order: a new key is placed after all existing equal keys.
//   - push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the same edge.
//   - in_ready = ~full | out_ready (combinational path from out_ready); in_ready=0 while clear=1.
//   - Insert slot k = number of valid entries e[i] with !better(in_data, e[i]).
//   - Push only: e[i+1]<=e[i] for i>=k; e[k]<=in_data; count+1.
//   - Pop only: e[i]<=e[i+1]; last valid slot becomes e=0,v=0; count-1.
//   - Push+pop: result identical to pop then insert into the remaining set; count unchanged.
//     Legal when full; legal when count==1, where the new key becomes top.
//   - Pop when empty is ignored (out_valid=0). Push when full without pop is refused (in_ready=0).
//     in_data is not stored and the contents are unchanged.
//   - clear=1 at posedge: all entries emptied; push/pop that cycle are ignored.
//   - Latency: an accepted key is visible on top/count the cycle after the edge (1 cycle).
//     top, count, full and empty are registered-state decodes, with no combinational path from inputs.
//   - Each slot is updated through a 4-way select {hold, take-new, take-from-above, take-from-below}.
//     The per-slot select is derived from a thermometer of compares and the push/pop flags.
// TESTING
//   1. Reset then push 5,9,1,9 (MAX_FIRST=1) -> top=9, count=4; then pop x4 -> 9,9,5,1.
//      The second 9 emerges after the first; then empty=1, top=0.
//   2. Fill DEPTH=6 with 10..15; push 20 with out_ready=0 -> in_ready=0, contents unchanged, full=1.
//   3. Full queue 10..15; push 12 with out_ready=1 -> 15 popped; next tops 14,13,12,12,11,10.
//      count stays 6.
//   4. MAX_FIRST=0, push 7,3,200,3 -> pops yield 3,3,7,200. Pop on empty -> no change, out_valid=0.
//   5. Queue holding 4 keys, assert clear with in_valid=1 -> count=0 next cycle, key not stored.
//   6. Assert r asynchronously between edges with 3 entries -> top=0, count=0 before the next posedge.
//      A push on the first edge after release is accepted normally.

Source files
------------

// File: rtl/pri_queue_param.sv
// Sorted priority queue with configurable depth and ordering. Entry 0 is always the best key.
// Each slot chooses hold / new key / neighbour above / neighbour below on every accepted transfer.
module pri_queue_param #(
    parameter int W         = 8,
    parameter int DEPTH     = 6,
    parameter int MAX_FIRST = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic          ck,
    input  logic          r,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_NEW,
        SEL_ABOVE,
        SEL_BELOW
    } sel_t;

    logic [W-1:0]     e     [DEPTH];
    logic [DEPTH-1:0] v;
    logic [W-1:0]     e_nxt [DEPTH];
    logic [DEPTH-1:0] v_nxt;
    sel_t             sel   [DEPTH];

    // Padded copies: index i+1 is slot i, so neighbours of the end slots read as empty.
    logic [W-1:0]     ep    [DEPTH+2];
    logic [DEPTH+1:0] vp;
    logic [DEPTH+1:0] gp;

    logic push;
    logic pop;

    function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b);
        if (MAX_FIRST != 0) return a > b;
        else                return a < b;
    endfunction

    assign empty     = ~v[0];
    assign full      = v[DEPTH-1];
    assign out_valid = v[0];
    assign top       = v[0] ? e[0] : '0;
    assign in_ready  = ~clear & (~full | out_ready);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~clear;

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) count = count + CW'(v[i]);
    end

    // gp[i+1] marks slots the new key must stay behind; gp[0]=1 lets slot 0 be the first free slot.
    always_comb begin
        gp        = '0;
        vp        = '0;
        gp[0]     = 1'b1;
        ep[0]     = '0;
        ep[DEPTH+1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ep[i+1] = e[i];
            vp[i+1] = v[i];
            gp[i+1] = v[i] & ~better(in_data, e[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = SEL_HOLD;
            if (push && pop) begin
                if (gp[i+2])                     sel[i] = SEL_BELOW;
                else if (gp[i+1] || (i == 0))    sel[i] = SEL_NEW;
            end else if (push) begin
                if (!gp[i+1])                    sel[i] = gp[i] ? SEL_NEW : SEL_ABOVE;
            end else if (pop) begin
                sel[i] = SEL_BELOW;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            e_nxt[i] = e[i];
            v_nxt[i] = v[i];
            case (sel[i])
                SEL_NEW:   begin e_nxt[i] = in_data; v_nxt[i] = 1'b1;    end
                SEL_ABOVE: begin e_nxt[i] = ep[i];   v_nxt[i] = vp[i];   end
                SEL_BELOW: begin e_nxt[i] = ep[i+2]; v_nxt[i] = vp[i+2]; end
                default:   begin e_nxt[i] = e[i];    v_nxt[i] = v[i];    end
            endcase
        end
    end

    // Reset and clear both empty every slot; clear also swallows any push/pop of that cycle.
    always_ff @(posedge ck or posedge r) begin
        if (r) begin
            for (int i = 0; i < DEPTH; i++) e[i] <= '0;
            v <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) e[i] <= '0;
            v <= '0;
        end else if (push || pop) begin
            for (int i = 0; i < DEPTH; i++) e[i] <= e_nxt[i];
            v <= v_nxt;
        end
    end

endmodule

// File: tb/tb_pri_queue_param.sv
// Bench for pri_queue_param: a max-first instance driven from a vector table against a
// behavioural sorted-list model, plus a min-first instance and reset/clear sequences.
module tb_pri_queue_param;

    localparam int W     = 8;
    localparam int DEPTH = 6;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          ck = 1'b0;
    logic          r;
    logic          clear;
    logic          in_valid, out_ready, in_valid_b, out_ready_b;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid, full, empty;
    logic [W-1:0]  top;
    logic [CW-1:0] count;
    logic          in_ready_b, out_valid_b, full_b, empty_b;
    logic [W-1:0]  top_b;
    logic [CW-1:0] count_b;

    pri_queue_param #(.W(W), .DEPTH(DEPTH), .MAX_FIRST(1)) dut (
        .ck(ck), .r(r), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .top(top),
        .count(count), .full(full), .empty(empty)
    );

    pri_queue_param #(.W(W), .DEPTH(DEPTH), .MAX_FIRST(0)) dut_min (
        .ck(ck), .r(r), .clear(clear), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready_b), .top(top_b),
        .count(count_b), .full(full_b), .empty(empty_b)
    );

    always #5 ck = ~ck;

    typedef struct {
        bit        iv;
        bit [7:0]  d;
        bit        ordy;
        bit        clr;
        bit [7:0]  etop;
        int        ecnt;
    } vec_t;

    vec_t vt[$];
    int   mq[$];
    int   expq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void addVec(bit iv, int d, bit ordy, bit clr, int etop, int ecnt);
        vec_t x;
        x.iv = iv; x.d = 8'(d); x.ordy = ordy; x.clr = clr; x.etop = 8'(etop); x.ecnt = ecnt;
        vt.push_back(x);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive one cycle on the max-first queue, predicting it with the sorted-list model.
    task automatic applyStimulus(input bit iv, input int d, input bit ordy, input bit clr);
        bit ird_m, push_m, pop_m;
        int k;
        @(negedge ck);
        in_valid = iv; in_data = 8'(d); out_ready = ordy; clear = clr;
        #1;
        ird_m  = !clr && ((mq.size() != DEPTH) || ordy);
        push_m = iv && ird_m;
        pop_m  = !clr && ordy && (mq.size() > 0);
        checkOutput("in_ready", int'(in_ready), int'(ird_m));
        if (clr) begin
            mq.delete();
        end else begin
            if (pop_m) expq.push_back(mq.pop_front());
            if (push_m) begin
                k = 0;
                while (k < mq.size() && !(d > mq[k])) k++;
                mq.insert(k, d);
            end
        end
        if (pop_m) checkOutput("popped_key", int'(top), expq.pop_front());
        @(posedge ck);
        #1;
        checkOutput("model_top",   int'(top),       (mq.size() > 0) ? mq[0] : 0);
        checkOutput("model_count", int'(count),     mq.size());
        checkOutput("model_full",  int'(full),      int'(mq.size() == DEPTH));
        checkOutput("model_empty", int'(empty),     int'(mq.size() == 0));
        checkOutput("model_valid", int'(out_valid), int'(mq.size() != 0));
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic stepMin(input bit iv, input int d, input bit ordy);
        @(negedge ck);
        in_valid_b = iv; in_data = 8'(d); out_ready_b = ordy;
        #1;
        if (ordy && out_valid_b) checkOutput("min_popped", int'(top_b), expq.pop_front());
        @(posedge ck);
        #1;
        in_valid_b = 1'b0; out_ready_b = 1'b0;
    endtask

    initial begin
        r = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; in_data = '0;

        addVec(1, 5, 0, 0, 5, 1);   addVec(1, 9, 0, 0, 9, 2);   addVec(1, 1, 0, 0, 9, 3);
        addVec(1, 9, 0, 0, 9, 4);   addVec(0, 0, 1, 0, 9, 3);   addVec(0, 0, 1, 0, 5, 2);
        addVec(0, 0, 1, 0, 1, 1);   addVec(0, 0, 1, 0, 0, 0);   addVec(0, 0, 1, 0, 0, 0);
        for (int i = 10; i <= 15; i++) addVec(1, i, 0, 0, i, i - 9);
        addVec(1, 20, 0, 0, 15, 6);
        addVec(1, 12, 1, 0, 14, 6); addVec(0, 0, 1, 0, 13, 5);  addVec(0, 0, 1, 0, 12, 4);
        addVec(0, 0, 1, 0, 12, 3);  addVec(0, 0, 1, 0, 11, 2);  addVec(0, 0, 1, 0, 10, 1);
        addVec(1, 3, 1, 0, 3, 1);   addVec(0, 0, 1, 0, 0, 0);
        addVec(1, 1, 0, 0, 1, 1);   addVec(1, 2, 0, 0, 2, 2);   addVec(1, 3, 0, 0, 3, 3);
        addVec(1, 4, 0, 0, 4, 4);   addVec(1, 99, 0, 1, 0, 0);  addVec(1, 7, 0, 0, 7, 1);
        addVec(0, 0, 1, 0, 0, 0);

        #12;
        checkOutput("rst_count",    int'(count),     0);
        checkOutput("rst_empty",    int'(empty),     1);
        checkOutput("rst_full",     int'(full),      0);
        checkOutput("rst_valid",    int'(out_valid), 0);
        checkOutput("rst_top",      int'(top),       0);
        checkOutput("rst_in_ready", int'(in_ready),  1);
        checkOutput("rst_min_count", int'(count_b),  0);
        #1 r = 1'b0;

        // Min-first ordering with duplicate keys, then a pop on an empty queue.
        stepMin(1, 7, 0); stepMin(1, 3, 0); stepMin(1, 200, 0); stepMin(1, 3, 0);
        checkOutput("min_count4", int'(count_b), 4);
        checkOutput("min_top4",   int'(top_b),   3);
        expq.push_back(3); expq.push_back(3); expq.push_back(7); expq.push_back(200);
        for (int i = 0; i < 4; i++) stepMin(0, 0, 1);
        stepMin(0, 0, 1);
        checkOutput("min_empty_valid", int'(out_valid_b), 0);
        checkOutput("min_empty_count", int'(count_b),     0);
        checkOutput("min_empty_top",   int'(top_b),       0);
        checkOutput("min_scoreboard_drained", expq.size(), 0);

        for (int i = 0; i < vt.size(); i++) begin
            applyStimulus(vt[i].iv, int'(vt[i].d), vt[i].ordy, vt[i].clr);
            checkOutput($sformatf("vec%0d_top", i),   int'(top),   int'(vt[i].etop));
            checkOutput($sformatf("vec%0d_count", i), int'(count), vt[i].ecnt);
        end

        // Asynchronous reset between edges with three entries held.
        applyStimulus(1, 1, 0, 0); applyStimulus(1, 2, 0, 0); applyStimulus(1, 3, 0, 0);
        checkOutput("pre_areset_count", int'(count), 3);
        @(negedge ck);
        #2 r = 1'b1;
        #1;
        checkOutput("areset_top",   int'(top),   0);
        checkOutput("areset_count", int'(count), 0);
        checkOutput("areset_empty", int'(empty), 1);
        #1 r = 1'b0;
        mq.delete();
        applyStimulus(1, 8, 0, 0);
        checkOutput("post_areset_top",   int'(top),   8);
        checkOutput("post_areset_count", int'(count), 1);
        checkOutput("scoreboard_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
